// File: rtl/ram_responder_if.sv
// Shared word/status types and the request/response bundle between the
// memory controller (master) and the RAM model (slave).
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

interface ram_responder_if;
    logic                      ramREN;
    logic                      ramWEN;
    cpu_types_pkg::word_t      ramaddr;
    cpu_types_pkg::word_t      ramstore;
    cpu_types_pkg::word_t      ramload;
    cpu_types_pkg::ramstate_t  ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM model with LAT busy cycles before a single ACCESS cycle;
// a dropped or changed request abandons the access in flight.
module ram_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input  logic            CLK,
    input  logic            nRST,
    ram_responder_if.slave  ram
);
    import cpu_types_pkg::*;

    localparam int         AW        = $clog2(DEPTH);
    localparam bit         ZERO_LAT  = (LAT == 0);
    localparam logic [3:0] CNT_INIT  = 4'((LAT > 0) ? LAT - 1 : 0);

    logic          r_active;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_tag_addr;
    logic          r_tag_wen;
    word_t         r_mem [DEPTH];

    logic          w_req;
    logic          w_illegal;
    logic          w_legal;
    logic          w_match;
    logic          w_access;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr_bits;

    assign w_idx              = ram.ramaddr[2 +: AW];
    assign w_unused_addr_bits = ^ram.ramaddr[31:2+AW];

    assign w_req     = ram.ramREN | ram.ramWEN;
    assign w_illegal = (ram.ramREN & ram.ramWEN) | (w_req & (ram.ramaddr[1:0] != 2'b00));
    assign w_legal   = w_req & ~w_illegal;
    assign w_match   = r_active & (r_tag_addr == w_idx) & (r_tag_wen == ram.ramWEN);

    // With zero latency a fresh request completes in the cycle it appears.
    assign w_access  = w_legal & ((w_match & (r_cnt == 4'd0)) | (ZERO_LAT & ~w_match));

    always_comb begin
        // NOTE: default first so every path assigns ramstate and no latch is inferred.
        ram.ramstate = BUSY;
        if (w_illegal)     ram.ramstate = ERROR;
        else if (!w_req)   ram.ramstate = FREE;
        else if (w_access) ram.ramstate = ACCESS;
    end

    assign ram.ramload = (w_access && ram.ramREN) ? r_mem[w_idx] : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_active   <= 1'b0;
            r_cnt      <= 4'd0;
            r_tag_addr <= '0;
            r_tag_wen  <= 1'b0;
        end else if (!w_legal || w_access) begin
            r_active <= 1'b0;
        end else if (!w_match) begin
            r_active   <= 1'b1;
            r_tag_addr <= w_idx;
            r_tag_wen  <= ram.ramWEN;
            r_cnt      <= CNT_INIT;
        end else begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // NOTE: storage is deliberately reset to zero so simulations start from known memory.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_access && ram.ramWEN) begin
            r_mem[w_idx] <= ram.ramstore;
        end
    end
endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: a LAT=2 and a LAT=0 instance share directed stimulus
// and are compared each cycle against a request-age model plus literal expectations.
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int LAT_A = 2;
    localparam int LAT_B = 0;
    localparam int DEPTH = 1024;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    ram_responder_if if_a();
    ram_responder_if if_b();

    ram_responder #(.LAT(LAT_A), .DEPTH(DEPTH)) dut_a (.CLK(CLK), .nRST(nRST), .ram(if_a.slave));
    ram_responder #(.LAT(LAT_B), .DEPTH(DEPTH)) dut_b (.CLK(CLK), .nRST(nRST), .ram(if_b.slave));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a legal request that has been presented unchanged for LAT cycles
    // since it started is granted; a grant ends the run.
    int          m_age   [2];
    bit          m_valid [2];
    logic [9:0]  m_idx   [2];
    logic        m_wen   [2];
    logic [31:0] m_mem   [2][DEPTH];

    task automatic model_cycle(input int d, input int lat, input logic ren, input logic wen,
                               input logic [31:0] addr, input logic [31:0] store,
                               input ramstate_t st, input logic [31:0] ld);
        logic [9:0]  idx;
        ramstate_t   exp_st;
        logic [31:0] exp_ld;
        idx    = addr[11:2];
        exp_ld = '0;
        if (!ren && !wen) begin
            exp_st     = FREE;
            m_valid[d] = 1'b0;
        end else if ((ren && wen) || addr[1:0] != 2'b00) begin
            exp_st     = ERROR;
            m_valid[d] = 1'b0;
        end else begin
            if (!m_valid[d] || m_idx[d] != idx || m_wen[d] != wen) begin
                m_valid[d] = 1'b1;
                m_age[d]   = 0;
                m_idx[d]   = idx;
                m_wen[d]   = wen;
            end
            if (m_age[d] == lat) begin
                exp_st = ACCESS;
                if (ren) exp_ld = m_mem[d][idx];
                else     m_mem[d][idx] = store;
                m_valid[d] = 1'b0;
            end else begin
                exp_st = BUSY;
                m_age[d]++;
            end
        end
        check($sformatf("model%0d_state", d), 32'(st), 32'(exp_st));
        check($sformatf("model%0d_load", d), ld, exp_ld);
    endtask

    always @(negedge CLK) begin
        if (nRST !== 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                m_valid[d] = 1'b0;
                m_age[d]   = 0;
                for (int i = 0; i < DEPTH; i++) m_mem[d][i] = '0;
            end
        end else begin
            model_cycle(0, LAT_A, if_a.ramREN, if_a.ramWEN, if_a.ramaddr, if_a.ramstore,
                        if_a.ramstate, if_a.ramload);
            model_cycle(1, LAT_B, if_b.ramREN, if_b.ramWEN, if_b.ramaddr, if_b.ramstore,
                        if_b.ramstate, if_b.ramload);
        end
    end

    // One clock cycle of stimulus, applied just after the edge; returns at mid-cycle.
    task automatic step(input logic rst, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] store);
        @(posedge CLK);
        #1;
        nRST          = rst;
        if_a.ramREN   = ren;  if_b.ramREN   = ren;
        if_a.ramWEN   = wen;  if_b.ramWEN   = wen;
        if_a.ramaddr  = addr; if_b.ramaddr  = addr;
        if_a.ramstore = store; if_b.ramstore = store;
        @(negedge CLK);
    endtask

    task automatic rd(input logic [31:0] addr);
        step(1'b1, 1'b1, 1'b0, addr, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        step(1'b1, 1'b0, 1'b1, addr, data);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic lit(input int d, input string name, input ramstate_t st, input logic [31:0] ld);
        if (d == 0) begin
            check({name, "_state"}, 32'(if_a.ramstate), 32'(st));
            check({name, "_load"}, if_a.ramload, ld);
        end else begin
            check({name, "_state"}, 32'(if_b.ramstate), 32'(st));
            check({name, "_load"}, if_b.ramload, ld);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if_a.ramREN = 1'b0; if_a.ramWEN = 1'b0; if_a.ramaddr = '0; if_a.ramstore = '0;
        if_b.ramREN = 1'b0; if_b.ramWEN = 1'b0; if_b.ramaddr = '0; if_b.ramstore = '0;

        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        lit(0, "reset_free", FREE, 32'h0);
        idle();
        lit(0, "idle_free", FREE, 32'h0);

        // Read after reset
        rd(32'h40); lit(0, "rd0_c0", BUSY, 32'h0); lit(1, "lat0_rd0", ACCESS, 32'h0);
        rd(32'h40); lit(0, "rd0_c1", BUSY, 32'h0);
        rd(32'h40); lit(0, "rd0_c2", ACCESS, 32'h0);
        idle();     lit(0, "rd0_after", FREE, 32'h0);

        // Write then read, including address wrap
        wr(32'h40, 32'hDEADBEEF); lit(0, "wr1_c0", BUSY, 32'h0);
        wr(32'h40, 32'hDEADBEEF); lit(0, "wr1_c1", BUSY, 32'h0);
        wr(32'h40, 32'hDEADBEEF); lit(0, "wr1_c2", ACCESS, 32'h0);
        idle();
        rd(32'h40); lit(0, "rd1_c0", BUSY, 32'h0); lit(1, "lat0_rd1", ACCESS, 32'hDEADBEEF);
        rd(32'h40);
        rd(32'h40); lit(0, "rd1_c2", ACCESS, 32'hDEADBEEF);
        rd(32'h1040);
        rd(32'h1040);
        rd(32'h1040); lit(0, "rd_wrap", ACCESS, 32'hDEADBEEF);
        idle();

        // Address change mid-BUSY on a read
        repeat (3) wr(32'h84, 32'hA5A50084);
        idle();
        rd(32'h80); lit(0, "chg_c0", BUSY, 32'h0);
        rd(32'h84); lit(0, "chg_c1", BUSY, 32'h0);
        rd(32'h84); lit(0, "chg_c2", BUSY, 32'h0);
        rd(32'h84); lit(0, "chg_c3", ACCESS, 32'hA5A50084);
        idle();

        // Address change mid-write: old word stays unwritten
        wr(32'h90, 32'h11111111);
        wr(32'h94, 32'h22222222);
        wr(32'h94, 32'h22222222);
        wr(32'h94, 32'h22222222); lit(0, "wchg_acc", ACCESS, 32'h0);
        idle();
        repeat (2) rd(32'h90);
        rd(32'h90); lit(0, "wchg_old", ACCESS, 32'h0);
        repeat (2) rd(32'h94);
        rd(32'h94); lit(0, "wchg_new", ACCESS, 32'h22222222);
        idle();

        // Illegal requests
        step(1'b1, 1'b1, 1'b1, 32'h40, 32'h0); lit(0, "ill_both", ERROR, 32'h0);
        wr(32'h42, 32'h00000BAD);              lit(0, "ill_align", ERROR, 32'h0);
        lit(1, "lat0_ill_align", ERROR, 32'h0);
        rd(32'h40);                            lit(0, "ill_pre", BUSY, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h40, 32'h0); lit(0, "ill_mid", ERROR, 32'h0);
        rd(32'h40); lit(0, "ill_post_c0", BUSY, 32'h0);
        rd(32'h40); lit(0, "ill_post_c1", BUSY, 32'h0);
        rd(32'h40); lit(0, "ill_post_c2", ACCESS, 32'hDEADBEEF);
        idle();

        // Held request repeats with period LAT+1
        repeat (3) wr(32'h10, 32'h0F0F0F0F);
        idle();
        rd(32'h10); lit(0, "hold_0", BUSY, 32'h0);
        rd(32'h10); lit(0, "hold_1", BUSY, 32'h0);
        rd(32'h10); lit(0, "hold_2", ACCESS, 32'h0F0F0F0F);
        rd(32'h10); lit(0, "hold_3", BUSY, 32'h0);
        rd(32'h10); lit(0, "hold_4", BUSY, 32'h0);
        rd(32'h10); lit(0, "hold_5", ACCESS, 32'h0F0F0F0F);
        rd(32'h10); lit(0, "hold_6", BUSY, 32'h0);
        idle();

        // Reset during BUSY #2 of a write
        wr(32'h20, 32'h12345678);               lit(0, "rstw_c0", BUSY, 32'h0);
        lit(1, "lat0_rstw", ACCESS, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678); lit(0, "rstw_in_reset", BUSY, 32'h0);
        idle();                                 lit(0, "rstw_release", FREE, 32'h0);
        rd(32'h20); lit(1, "lat0_rstw_rd", ACCESS, 32'h0);
        rd(32'h20);
        rd(32'h20); lit(0, "rstw_rd", ACCESS, 32'h0);
        rd(32'h40);
        rd(32'h40);
        rd(32'h40); lit(0, "rst_cleared", ACCESS, 32'h0);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_responder.md
# ram_responder

Word-addressed RAM model sitting on the RAM side of the memory controller: it answers the `ramREN`/`ramWEN`/`ramaddr`/`ramstore` requests and returns `ramload` plus a `ramstate` status. Each access costs a parameterised number of BUSY cycles followed by exactly one ACCESS cycle. Dropping or changing a request aborts the access, and the next request starts a fresh one. It is the synthesizable stand-in for external memory in system simulation and in the coherence-controller bench.

## Interface
- `LAT`, default 2: BUSY cycles before ACCESS; legal range 0..15.
- `DEPTH`, default 1024: words of storage; must be a power of two.
- `CLK` in, 1 bit: clock; all state changes on the rising edge.
- `nRST` in, 1 bit: reset, asynchronous, active-low.
- `ramREN` in, 1 bit: read request, level-held by the requester until ACCESS.
- `ramWEN` in, 1 bit: write request, level-held by the requester until ACCESS.
- `ramaddr` in, `word_t` (32 bits): byte address.
- `ramstore` in, `word_t` (32 bits): write data; sampled on the edge closing the write ACCESS cycle.
- `ramload` out, `word_t` (32 bits): read data; valid only during a read ACCESS cycle, otherwise 0.
- `ramstate` out, `ramstate_t` (`cpu_types_pkg`): FREE / BUSY / ACCESS / ERROR.

## Operation
- Word index is `ramaddr[2 +: $clog2(DEPTH)]`. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- **Request cycle:** `ramREN` or `ramWEN` is high.
- **Request kind:**
  - A request is *illegal* if `ramREN && ramWEN`, or if `ramaddr[1:0] != 0`.
  - Otherwise the request is *legal*.
- **Internal registers:**
  - `active` (1b)
  - `cnt` (4b)
  - `tag_addr` (word index)
  - `tag_wen` (1b)
- **`ramstate` is combinational from inputs and registers, in priority order:**
  - ERROR: illegal request. No storage change. Registers clear `active`.
  - FREE: no request. Registers clear `active`.
  - ACCESS: legal request, `active`, tag matches (`tag_addr`==index, `tag_wen`==`ramWEN`), and `cnt`==0.
  - ACCESS (LAT=0 only): a new legal request (not active, or tag mismatch) goes ACCESS in the same cycle.
  - BUSY: all other legal requests.
- **New legal request** (not active, or tag mismatch), LAT≥1:
  - Load `tag_*`.
  - Set `active`=1.
  - Set `cnt`=LAT-1.
  - The current cycle is BUSY #1.
- **Matched BUSY cycle:** `cnt` decrements.
- **ACCESS cycle:**
  - Read: `ramload` = mem[index], combinational.
  - Write: mem[index] <= `ramstore` on the closing edge.
  - On that edge `active` clears, so a request still held unchanged afterwards starts a new access (re-read or re-write).
- **Tag mismatch mid-access** (address or op changed): the old access is abandoned with no write, and the counter restarts for the new request.
- **Reset:**
  - Storage cleared to 0.
  - `active`=0, `cnt`=0, tags 0.
  - Outputs: `ramstate`=FREE if no request, `ramload`=0.
  - An in-flight write is lost and storage is not modified.

## Timing
- A legal request first presented in cycle t, held unchanged, sees BUSY in t..t+LAT-1 and ACCESS in t+LAT.
- A held request repeats with period LAT+1.
- Write data becomes visible to a read whose ACCESS falls in cycle t+LAT+1 or later.
- A read ACCESS in the same cycle as the write ACCESS is impossible, since there is a single port.
- The requester samples `ramload` in the ACCESS cycle only.
- No output depends on `ramstore` combinationally.
- ERROR and FREE take effect in the same cycle as the input change; neither consumes a counter cycle.

## Test plan
- **Read after reset:** reset, then `ramREN`=1, `ramaddr`=0x40 at t (LAT=2) -> BUSY t, t+1; ACCESS t+2 with `ramload`=0x00000000; `ramload`=0 in all other cycles.
- **Write then read:** write 0xDEADBEEF to 0x40 (ACCESS at t+2), drop WEN, then read 0x40 -> ACCESS 2 cycles after REN rises, `ramload`=0xDEADBEEF. Read 0x1040 (wraps for DEPTH=1024) -> 0xDEADBEEF.
- **Address change mid-BUSY:** read 0x80 at t, change to 0x84 at t+1 -> BUSY t..t+2, ACCESS at t+3 returns mem[0x84]. Mid-write change: the old address is unwritten.
- **Illegal requests:** `ramREN` and `ramWEN` both high, or `ramaddr`=0x42 -> ERROR that cycle, storage unchanged (read back the old value); a later legal request is serviced with full LAT latency.
- **Held request:** `ramREN` held on 0x10 for 7 cycles from t -> ACCESS at t+2 and t+5, BUSY elsewhere.
- **Reset mid-write:** write 0x12345678 to 0x20, pull `nRST` low during BUSY #2 -> `ramstate`=FREE/BUSY restart after release, and a subsequent read of 0x20 returns 0. Repeat with LAT=0: ACCESS in the first request cycle.
